// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; Busy stalls the pipeline.
// Define HILO_FAST_MULT_EN for a single-cycle combinational multiply path (divide stays iterative).
module hilo_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] OperandA,
    input  logic [DATA_W-1:0] OperandB,
    input  logic              HiWrite,
    input  logic              LoWrite,
    input  logic [DATA_W-1:0] MoveData,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, stateNext;

    logic [CNT_W-1:0]  cnt;
    logic              isDivReg;
    logic              negRes;
    logic              negRem;
    logic              divZero;
    logic [DATA_W-1:0] operandReg;
    logic [DATA_W-1:0] accHi;
    logic [DATA_W-1:0] accLo;
    logic [DATA_W-1:0] hiReg;
    logic [DATA_W-1:0] loReg;

    logic              launch;
    logic              fastPath;
    logic              isSigned;
    logic [DATA_W-1:0] magA;
    logic [DATA_W-1:0] magB;

    assign launch   = ((state == IDLE) || (state == DONE)) && Start;
    assign isSigned = ~Op[0];
    assign magA     = (isSigned && OperandA[DATA_W-1]) ? -OperandA : OperandA;
    assign magB     = (isSigned && OperandB[DATA_W-1]) ? -OperandB : OperandB;

`ifdef HILO_FAST_MULT_EN
    logic [2*DATA_W-1:0] fastProd;
    assign fastProd = {{DATA_W{1'b0}}, magA} * {{DATA_W{1'b0}}, magB};
    assign fastPath = ~Op[1];
`else
    assign fastPath = 1'b0;
`endif

    // Shift-add multiply step: accLo holds the remaining multiplier bits.
    logic [DATA_W:0]   mulSum;
    logic [DATA_W-1:0] mulHi;
    logic [DATA_W-1:0] mulLo;
    assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operandReg} : {(DATA_W+1){1'b0}});
    assign mulHi  = mulSum[DATA_W:1];
    assign mulLo  = {mulSum[0], accLo[DATA_W-1:1]};

    // Restoring divide step: the partial remainder stays below 2*divisor, so bit DATA_W is the borrow.
    logic [DATA_W:0]   divShift;
    logic [DATA_W:0]   divTrial;
    logic              divFits;
    logic [DATA_W-1:0] divHi;
    logic [DATA_W-1:0] divLo;
    assign divShift = {accHi, accLo[DATA_W-1]};
    assign divTrial = divShift - {1'b0, operandReg};
    assign divFits  = ~divTrial[DATA_W];
    assign divHi    = divFits ? divTrial[DATA_W-1:0] : divShift[DATA_W-1:0];
    assign divLo    = {accLo[DATA_W-2:0], divFits};

    // Sign correction applied on the FIX edge.
    logic [2*DATA_W-1:0] prodMag;
    logic [2*DATA_W-1:0] prodFinal;
    logic [DATA_W-1:0]   quoFinal;
    logic [DATA_W-1:0]   remFinal;
    assign prodMag   = {accHi, accLo};
    assign prodFinal = negRes ? -prodMag : prodMag;
    assign quoFinal  = divZero ? {DATA_W{1'b1}} : (negRes ? -accLo : accLo);
    assign remFinal  = negRem ? -accHi : accHi;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: stateNext = Start ? (fastPath ? FIX : RUN) : IDLE;
            RUN:        if (cnt == CNT_W'(DATA_W - 1)) stateNext = FIX;
            FIX:        stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            RUN, FIX: Busy = 1'b1;
            DONE:     Done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt        <= '0;
            isDivReg   <= 1'b0;
            negRes     <= 1'b0;
            negRem     <= 1'b0;
            divZero    <= 1'b0;
            operandReg <= '0;
            accHi      <= '0;
            accLo      <= '0;
        end else if (launch) begin
            cnt        <= '0;
            isDivReg   <= Op[1];
            negRes     <= isSigned && (OperandA[DATA_W-1] ^ OperandB[DATA_W-1]);
            negRem     <= isSigned && OperandA[DATA_W-1];
            divZero    <= Op[1] && (OperandB == '0);
            operandReg <= Op[1] ? magB : magA;
            accHi      <= '0;
            accLo      <= Op[1] ? magA : magB;
`ifdef HILO_FAST_MULT_EN
            if (!Op[1]) {accHi, accLo} <= fastProd;
`endif
        end else if (state == RUN) begin
            cnt   <= cnt + 1'b1;
            accHi <= isDivReg ? divHi : mulHi;
            accLo <= isDivReg ? divLo : mulLo;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (state == FIX) begin
            hiReg <= isDivReg ? remFinal : prodFinal[2*DATA_W-1:DATA_W];
            loReg <= isDivReg ? quoFinal : prodFinal[DATA_W-1:0];
        end else if (!Busy) begin
            if (HiWrite) hiReg <= MoveData;
            if (LoWrite) loReg <= MoveData;
        end
    end

    assign Hi = hiReg;
    assign Lo = loReg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed operations, moves, ignored Start and mid-operation reset.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         HiWrite;
    logic         LoWrite;
    logic [W-1:0] MoveData;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    hilo_muldiv_unit #(.DATA_W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .MoveData(MoveData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   edgeCnt   = 0;
    int   doneCount = 0;

    always @(posedge Clk) edgeCnt <= edgeCnt + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every Done cycle must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            exp_t e;
            doneCount++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=Done=1 required=no pending operation (cycle %0d)", edgeCnt);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, Hi, e.hi);
                chk({e.name, "_lo"}, Lo, e.lo);
                chk({e.name, "_cycle"}, W'(edgeCnt), W'(e.cyc));
                chk({e.name, "_busy_at_done"}, W'(Busy), W'(0));
                $display("op %s done at cycle %0d Hi=%h Lo=%h", e.name, edgeCnt, Hi, Lo);
            end
        end
    end

    function automatic int latency(input logic [1:0] op);
`ifdef HILO_FAST_MULT_EN
        if (!op[1]) return 1;
`endif
        return W + 1;
    endfunction

    task automatic waitDone(input string name, input int d0);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk); #1;
            if (doneCount != d0) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout actual=no Done required=Done within 100 cycles", name);
        end else begin
            @(negedge Clk); #1;
            chk({name, "_done_pulse"}, W'(Done), W'(0));
        end
    endtask

    task automatic launchOp(input string name, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] eHi, input logic [W-1:0] eLo);
        @(negedge Clk);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        sb.push_back('{eHi, eLo, edgeCnt + latency(op), name});
        chk({name, "_busy_rise"}, W'(Busy), W'(1));
    endtask

    task automatic runOp(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eHi, input logic [W-1:0] eLo);
        int d0 = doneCount;
        launchOp(name, op, a, b, eHi, eLo);
        waitDone(name, d0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0;
        logic [W-1:0] prevHi;
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; MoveData = '0;
        repeat (3) @(negedge Clk);
        chk("reset_busy", W'(Busy), W'(0));
        chk("reset_done", W'(Done), W'(0));
        chk("reset_hi", Hi, '0);
        chk("reset_lo", Lo, '0);
        Reset = 1'b0;

        runOp("multu_ffffffff_x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        runOp("mult_m3_x7",        2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runOp("mult_minneg_sq",    2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        runOp("div_m7_2",          2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("div_7_m2",          2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        runOp("divu_100_7",        2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
        runOp("divu_by_zero",      2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
        runOp("div_m5_by_zero",    2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        runOp("div_overflow",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`ifdef HILO_FAST_MULT_EN
        runOp("multu_3x4_fast",    2'b01, 32'd3,         32'd4,         32'd0,         32'd12);
`endif

        // Moves while idle.
        @(negedge Clk); HiWrite = 1'b1; MoveData = 32'hCAFE_F00D;
        @(posedge Clk); #1; HiWrite = 1'b0;
        chk("mthi", Hi, 32'hCAFE_F00D);
        @(negedge Clk); LoWrite = 1'b1; MoveData = 32'h0BAD_BEEF;
        @(posedge Clk); #1; LoWrite = 1'b0;
        chk("mtlo", Lo, 32'h0BAD_BEEF);
        $display("moves Hi=%h Lo=%h", Hi, Lo);

        // Start together with MTLO: move lands first, result overwrites later.
        d0 = doneCount;
        @(negedge Clk);
        Start = 1'b1; Op = 2'b11; OperandA = 32'd50; OperandB = 32'd8;
        LoWrite = 1'b1; MoveData = 32'h1111_2222;
        @(posedge Clk); #1;
        Start = 1'b0; LoWrite = 1'b0;
        sb.push_back('{32'd2, 32'd6, edgeCnt + latency(2'b11), "divu_50_8_with_mtlo"});
        chk("start_mtlo_lo", Lo, 32'h1111_2222);
        waitDone("divu_50_8_with_mtlo", d0);

        // Start and MTHI while busy are ignored.
        d0 = doneCount;
`ifdef HILO_FAST_MULT_EN
        launchOp("busy_ignore", 2'b11, 32'd30, 32'd1, 32'd0, 32'd30);
`else
        launchOp("busy_ignore", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);
`endif
        repeat (9) @(negedge Clk);
        Start = 1'b1; Op = 2'b01; OperandA = 32'd9; OperandB = 32'd9;
        @(negedge Clk); Start = 1'b0;
        prevHi = Hi;
        @(negedge Clk); HiWrite = 1'b1; MoveData = 32'hDEAD_BEEF;
        @(posedge Clk); #1; HiWrite = 1'b0;
        chk("busy_mthi_ignored", Hi, prevHi);
        waitDone("busy_ignore", d0);

        // Reset in the middle of a divide abandons it.
        runOp("divu_100_7_again", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        d0 = doneCount;
        @(negedge Clk);
        Start = 1'b1; Op = 2'b10; OperandA = 32'd1000; OperandB = 32'd3;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (19) @(posedge Clk);
        #2; Reset = 1'b1; #1;
        chk("abort_busy", W'(Busy), W'(0));
        chk("abort_done", W'(Done), W'(0));
        chk("abort_hi", Hi, '0);
        chk("abort_lo", Lo, '0);
        $display("reset during DIV at cycle %0d Hi=%h Lo=%h", edgeCnt, Hi, Lo);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (50) @(negedge Clk);
        #1;
        chk("abort_no_done", W'(doneCount), W'(d0));
        chk("scoreboard_empty", W'(sb.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
